fetch_queue_stage: RTL

FETCH_QUEUE_STAGE -- requirements
Module: fetch_queue_stage

---
 rtl/fetch_queue_stage.sv | 123 ++++++++++++
 1 files changed

// File: rtl/fetch_queue_stage.sv
// Instruction fetch stage: issues sequential fetch requests, buffers in-order
// responses in a small circular queue and hands instructions to decode.
module fetch_queue_stage #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = 32'h00000000
) (
  input  logic            clk_i,
  input  logic            reset_ni,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            imem_req_valid_o,
  input  logic            imem_req_ready_i,
  output logic [XLEN-1:0] imem_req_addr_o,
  input  logic            imem_rsp_valid_i,
  input  logic [XLEN-1:0] imem_rsp_data_i,
  output logic            instr_valid_o,
  input  logic            instr_ready_i,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] instr_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  typedef logic [PW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;

  localparam ptr_t PTR_ONE  = ptr_t'(1);
  localparam cnt_t CNT_ONE  = cnt_t'(1);
  localparam cnt_t CNT_FULL = cnt_t'(DEPTH);

  logic [XLEN-1:0]  pc_q;
  logic [XLEN-1:0]  ent_pc_q    [DEPTH];
  logic [XLEN-1:0]  ent_instr_q [DEPTH];
  logic [DEPTH-1:0] ent_filled_q;

  ptr_t alloc_ptr_q, fill_ptr_q, rd_ptr_q;
  cnt_t count_q;
  // Allocated-but-unfilled entries, kept explicitly so a full queue of
  // pending requests is distinguishable from an empty one.
  cnt_t pend_q;
  cnt_t drop_q;
  cnt_t drop_redirect;

  logic req_fire, fill_fire, pop_fire;
  logic unused_pc_bits;

  assign unused_pc_bits = ^redirect_pc_i[1:0];

  assign imem_req_valid_o = reset_ni & ~redirect_i & (count_q < CNT_FULL) & (drop_q == '0);
  assign imem_req_addr_o  = pc_q;
  assign req_fire         = imem_req_valid_o & imem_req_ready_i;

  assign instr_valid_o = reset_ni & ~redirect_i & ent_filled_q[rd_ptr_q] & (count_q != '0);
  assign pc_o          = ent_pc_q[rd_ptr_q];
  assign instr_o       = ent_instr_q[rd_ptr_q];
  assign pop_fire      = instr_valid_o & instr_ready_i;

  // Responses with nothing left to fill are silently ignored.
  assign fill_fire = reset_ni & ~redirect_i & imem_rsp_valid_i & (drop_q == '0) & (pend_q != '0);

  always_comb begin
    // NOTE: assign a default first so every path drives the signal and no latch is inferred.
    drop_redirect = drop_q + pend_q;
    if (imem_rsp_valid_i && (drop_redirect != '0)) begin
      drop_redirect = drop_redirect - CNT_ONE;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      pc_q         <= RESET_PC;
      alloc_ptr_q  <= '0;
      fill_ptr_q   <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      pend_q       <= '0;
      drop_q       <= '0;
      ent_filled_q <= '0;
    end else if (redirect_i) begin
      pc_q         <= {redirect_pc_i[XLEN-1:2], 2'b00};
      alloc_ptr_q  <= '0;
      fill_ptr_q   <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      pend_q       <= '0;
      drop_q       <= drop_redirect;
      ent_filled_q <= '0;
    end else begin
      if (req_fire) begin
        pc_q                      <= pc_q + XLEN'(4);
        alloc_ptr_q               <= alloc_ptr_q + PTR_ONE;
        ent_filled_q[alloc_ptr_q] <= 1'b0;
      end
      if (fill_fire) begin
        fill_ptr_q               <= fill_ptr_q + PTR_ONE;
        ent_filled_q[fill_ptr_q] <= 1'b1;
      end
      if (pop_fire) begin
        rd_ptr_q               <= rd_ptr_q + PTR_ONE;
        ent_filled_q[rd_ptr_q] <= 1'b0;
      end
      if (imem_rsp_valid_i && (drop_q != '0)) begin
        drop_q <= drop_q - CNT_ONE;
      end
      count_q <= count_q + cnt_t'(req_fire) - cnt_t'(pop_fire);
      pend_q  <= pend_q + cnt_t'(req_fire) - cnt_t'(fill_fire);
    end
  end

  // NOTE: payload storage has no reset; the filled bits and count gate its visibility.
  always_ff @(posedge clk_i) begin
    if (req_fire) begin
      ent_pc_q[alloc_ptr_q] <= pc_q;
    end
    if (fill_fire) begin
      ent_instr_q[fill_ptr_q] <= imem_rsp_data_i;
    end
  end

endmodule
